// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin front end for the APB master transfer interface.
// One command is owned at a time. It is held on the APB outputs until the
// master reports completion or the timeout expires. Read data, or the
// timeout error, is then returned to the owning requester.
//
// state | meaning
// IDLE  | arbitrate; latch the winning command and grant it
// BUSY  | transfer held on the APB outputs; wait for apb_done or timeout
// DONE  | one-cycle completion pulse to the owner; update last-served
module apb_req_arbiter #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          r0_req,
  input  logic          r0_rw,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,
  input  logic          r1_req,
  input  logic          r1_rw,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,
  output logic          transfer,
  output logic          read_write,
  output logic [AW-1:0] apb_write_paddr,
  output logic [DW-1:0] apb_write_data,
  output logic [AW-1:0] apb_read_paddr,
  input  logic [DW-1:0] apb_read_data_out,
  input  logic          apb_done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Last BUSY cycle the counter can reach before the command is aborted.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]          state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                transfer_q, transfer_d;
  logic                rw_q, rw_d;
  logic [AW-1:0]       wpaddr_q, wpaddr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [AW-1:0]       rpaddr_q, rpaddr_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          done_q, done_d;
  logic [1:0]          err_q, err_d;
  logic [1:0][DW-1:0]  rdata_q, rdata_d;

  logic                win;
  logic                sel_rw;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;

  // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
  always_comb begin
    if (r0_req && r1_req) win = ~last_q;
    else                  win = r1_req;
    sel_rw    = win ? r1_rw    : r0_rw;
    sel_addr  = win ? r1_addr  : r0_addr;
    sel_wdata = win ? r1_wdata : r0_wdata;
  end

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    transfer_d = transfer_q;
    rw_d       = rw_q;
    wpaddr_d   = wpaddr_q;
    wdata_d    = wdata_q;
    rpaddr_d   = rpaddr_q;
    gnt_d      = 2'b00;
    done_d     = 2'b00;
    err_d      = err_q;
    rdata_d    = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (r0_req || r1_req) begin
          owner_d      = win;
          gnt_d[win]   = 1'b1;
          transfer_d   = 1'b1;
          rw_d         = sel_rw;
          cnt_d        = 8'd0;
          state_d      = ST_BUSY;
          if (sel_rw) begin
            rpaddr_d = sel_addr;
            wpaddr_d = '0;
            wdata_d  = '0;
          end else begin
            rpaddr_d = '0;
            wpaddr_d = sel_addr;
            wdata_d  = sel_wdata;
          end
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        // Completion beats the timeout when both land in the same cycle.
        if (apb_done || (cnt_q == CNT_LAST)) begin
          done_d[owner_q]  = 1'b1;
          err_d[owner_q]   = ~apb_done;
          rdata_d[owner_q] = (apb_done && rw_q) ? apb_read_data_out : '0;
          transfer_d       = 1'b0;
          rw_d             = 1'b0;
          wpaddr_d         = '0;
          wdata_d          = '0;
          rpaddr_d         = '0;
          state_d          = ST_DONE;
        end
      end

      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      cnt_q      <= 8'd0;
      transfer_q <= 1'b0;
      rw_q       <= 1'b0;
      wpaddr_q   <= '0;
      wdata_q    <= '0;
      rpaddr_q   <= '0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 2'b00;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      transfer_q <= transfer_d;
      rw_q       <= rw_d;
      wpaddr_q   <= wpaddr_d;
      wdata_q    <= wdata_d;
      rpaddr_q   <= rpaddr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign r0_gnt          = gnt_q[0];
  assign r1_gnt          = gnt_q[1];
  assign r0_done         = done_q[0];
  assign r1_done         = done_q[1];
  assign r0_err          = err_q[0];
  assign r1_err          = err_q[1];
  assign r0_rdata        = rdata_q[0];
  assign r1_rdata        = rdata_q[1];
  assign transfer        = transfer_q;
  assign read_write      = rw_q;
  assign apb_write_paddr = wpaddr_q;
  assign apb_write_data  = wdata_q;
  assign apb_read_paddr  = rpaddr_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_apb_req_arbiter;

  localparam int AW      = 9;
  localparam int DW      = 8;
  localparam int TIMEOUT = 16;

  logic          pclk;
  logic          preset;
  logic          r0_req, r0_rw, r1_req, r1_rw;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r0_done, r0_err, r1_gnt, r1_done, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          transfer, read_write;
  logic [AW-1:0] apb_write_paddr, apb_read_paddr;
  logic [DW-1:0] apb_write_data, apb_read_data_out;
  logic          apb_done;

  apb_req_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
    .apb_done(apb_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the command in flight as a transaction with an age
  // in BUSY cycles, and what every output must show in the following cycle.
  bit            m_busy, m_fin, m_owner, m_last, m_rw;
  int            m_age;
  bit            e_transfer, e_rw;
  bit [AW-1:0]   e_wpaddr, e_rpaddr;
  bit [DW-1:0]   e_wdata;
  bit [1:0]      e_gnt, e_done, e_err;
  bit [DW-1:0]   e_rdata [2];

  always @(posedge pclk) begin
    if (preset) begin
      m_busy = 0; m_fin = 0; m_last = 1; m_owner = 0; m_rw = 0; m_age = 0;
      e_transfer = 0; e_rw = 0; e_wpaddr = 0; e_rpaddr = 0; e_wdata = 0;
      e_gnt = 0; e_done = 0; e_err = 0; e_rdata[0] = 0; e_rdata[1] = 0;
    end else begin
      e_gnt = 0;
      e_done = 0;
      if (m_fin) begin
        m_fin  = 0;
        m_last = m_owner;
      end else if (m_busy) begin
        m_age++;
        if (apb_done || m_age == TIMEOUT) begin
          e_done[m_owner]  = 1;
          e_err[m_owner]   = !apb_done;
          e_rdata[m_owner] = (apb_done && m_rw) ? apb_read_data_out : '0;
          e_transfer = 0; e_rw = 0; e_wpaddr = 0; e_rpaddr = 0; e_wdata = 0;
          m_busy = 0;
          m_fin  = 1;
        end
      end else if (r0_req || r1_req) begin
        if (r0_req && r1_req) m_owner = !m_last;
        else                  m_owner = r1_req;
        m_rw = m_owner ? r1_rw : r0_rw;
        e_gnt[m_owner] = 1;
        e_transfer = 1;
        e_rw = m_rw;
        if (m_rw) begin
          e_rpaddr = m_owner ? r1_addr : r0_addr;
          e_wpaddr = 0;
          e_wdata  = 0;
        end else begin
          e_rpaddr = 0;
          e_wpaddr = m_owner ? r1_addr : r0_addr;
          e_wdata  = m_owner ? r1_wdata : r0_wdata;
        end
        m_busy = 1;
        m_age  = 0;
      end
    end
  end

  // Per-cycle compare, plus grant spacing/order and transfer-run bookkeeping.
  int cyc = 0;
  int last_gnt_cyc = -100;
  int run = 0;
  int last_run = 0;
  bit gnt_log[$];

  always @(negedge pclk) begin
    cyc++;
    if (chk_en) begin
      chk("transfer", transfer, e_transfer);
      chk("read_write", read_write, e_rw);
      chk("apb_write_paddr", apb_write_paddr, e_wpaddr);
      chk("apb_write_data", apb_write_data, e_wdata);
      chk("apb_read_paddr", apb_read_paddr, e_rpaddr);
      chk("r0_gnt", r0_gnt, e_gnt[0]);
      chk("r1_gnt", r1_gnt, e_gnt[1]);
      chk("r0_done", r0_done, e_done[0]);
      chk("r1_done", r1_done, e_done[1]);
      chk("r0_err", r0_err, e_err[0]);
      chk("r1_err", r1_err, e_err[1]);
      chk("r0_rdata", r0_rdata, e_rdata[0]);
      chk("r1_rdata", r1_rdata, e_rdata[1]);
      if (r0_gnt || r1_gnt) begin
        chk("gnt_spacing_ok", (cyc - last_gnt_cyc) >= 3, 1);
        last_gnt_cyc = cyc;
        gnt_log.push_back(r1_gnt);
      end
      if (transfer) run++;
      else if (run > 0) begin
        last_run = run;
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic wait_gnt();
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (r0_gnt || r1_gnt) begin
        got = 1;
        break;
      end
    end
    chk("gnt_wait", got, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    preset = 1; r0_req = 0; r0_rw = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_rw = 0; r1_addr = 0; r1_wdata = 0;
    apb_read_data_out = 0; apb_done = 0;

    // Reset state
    tick();
    chk_en = 1;
    chk("rst_transfer", transfer, 0);
    chk("rst_rdata0", r0_rdata, 0);
    chk("rst_gnt", {r0_gnt, r1_gnt}, 0);
    tick();
    preset = 0;
    tick();

    // Single write from r0, apb_done in the second BUSY cycle
    r0_req = 1; r0_rw = 0; r0_addr = 9'h005; r0_wdata = 8'hA5;
    wait_gnt();
    r0_req = 0;
    chk("w_gnt0", r0_gnt, 1);
    chk("w_transfer", transfer, 1);
    chk("w_paddr", apb_write_paddr, 9'h005);
    chk("w_data", apb_write_data, 8'hA5);
    chk("w_rpaddr", apb_read_paddr, 0);
    chk("w_rw", read_write, 0);
    tick();
    apb_done = 1;
    tick();
    apb_done = 0;
    chk("w_done0", r0_done, 1);
    chk("w_err0", r0_err, 0);
    chk("w_transfer_low", transfer, 0);
    tick();
    chk("w_run", last_run, 2);
    chk("w_done0_pulse", r0_done, 0);

    // Single read from r1
    r1_req = 1; r1_rw = 1; r1_addr = 9'h1FF; r1_wdata = 8'h99;
    wait_gnt();
    r1_req = 0;
    chk("r_gnt1", r1_gnt, 1);
    chk("r_rw", read_write, 1);
    chk("r_rpaddr", apb_read_paddr, 9'h1FF);
    chk("r_wpaddr", apb_write_paddr, 0);
    chk("r_wdata", apb_write_data, 0);
    apb_read_data_out = 8'h3C;
    apb_done = 1;
    tick();
    apb_done = 0;
    apb_read_data_out = 8'h11;
    chk("r_done1", r1_done, 1);
    chk("r_rdata1", r1_rdata, 8'h3C);
    tick();
    chk("r_done1_pulse", r1_done, 0);
    chk("r_rdata1_hold", r1_rdata, 8'h3C);
    chk("r_run", last_run, 1);

    // Contention: both requesting continuously for four commands
    gnt_log.delete();
    r0_rw = 1; r0_addr = 9'h010;
    r1_rw = 0; r1_addr = 9'h120; r1_wdata = 8'h77;
    apb_read_data_out = 8'h5A;
    r0_req = 1; r1_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt();
      apb_done = 1;
      tick();
      apb_done = 0;
    end
    r0_req = 0; r1_req = 0;
    tick();
    tick();
    chk("c_count", gnt_log.size(), 4);
    chk("c_order0", gnt_log[0], 0);
    chk("c_order1", gnt_log[1], 1);
    chk("c_order2", gnt_log[2], 0);
    chk("c_order3", gnt_log[3], 1);
    chk("c_rdata0", r0_rdata, 8'h5A);
    chk("c_rdata1", r1_rdata, 8'h00);

    // Timeout: read with no apb_done
    apb_read_data_out = 8'hEE;
    r0_req = 1; r0_rw = 1; r0_addr = 9'h0AA;
    wait_gnt();
    r0_req = 0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (r0_done) begin
        got = 1;
        break;
      end
    end
    chk("t_done_seen", got, 1);
    chk("t_err", r0_err, 1);
    chk("t_rdata", r0_rdata, 0);
    chk("t_transfer_low", transfer, 0);
    tick();
    chk("t_run", last_run, TIMEOUT);

    // apb_done in the last BUSY cycle wins over the timeout
    r0_req = 1; r0_addr = 9'h0AB;
    wait_gnt();
    r0_req = 0;
    repeat (TIMEOUT - 1) tick();
    apb_read_data_out = 8'h42;
    apb_done = 1;
    tick();
    apb_done = 0;
    chk("t16_done", r0_done, 1);
    chk("t16_err", r0_err, 0);
    chk("t16_rdata", r0_rdata, 8'h42);
    tick();
    chk("t16_run", last_run, TIMEOUT);

    // Reset in the third BUSY cycle, then a tie must go to r0
    r1_req = 1; r1_rw = 0; r1_addr = 9'h033; r1_wdata = 8'h5C;
    wait_gnt();
    chk("x_gnt1", r1_gnt, 1);
    tick();
    tick();
    preset = 1;
    r0_req = 1; r0_rw = 1; r0_addr = 9'h044;
    tick();
    preset = 0;
    chk("x_transfer", transfer, 0);
    chk("x_wpaddr", apb_write_paddr, 0);
    chk("x_wdata", apb_write_data, 0);
    chk("x_done1", r1_done, 0);
    chk("x_rdata0", r0_rdata, 0);
    wait_gnt();
    chk("x_tie_r0", r0_gnt, 1);
    chk("x_tie_not_r1", r1_gnt, 0);
    r0_req = 0; r1_req = 0;
    apb_read_data_out = 8'h81;
    apb_done = 1;
    tick();
    apb_done = 0;
    chk("x_rdata0_new", r0_rdata, 8'h81);
    tick();

    // Stray apb_done in IDLE, then held through DONE
    apb_done = 1;
    repeat (3) tick();
    apb_done = 0;
    chk("s_idle_transfer", transfer, 0);
    chk("s_idle_done", {r0_done, r1_done}, 0);
    r1_req = 1; r1_rw = 1; r1_addr = 9'h0F0;
    wait_gnt();
    r1_req = 0;
    apb_read_data_out = 8'h6B;
    apb_done = 1;
    tick();
    tick();
    tick();
    apb_done = 0;
    chk("s_rdata1", r1_rdata, 8'h6B);
    chk("s_done1", r1_done, 0);
    chk("s_transfer", transfer, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
